watchdog_multi: RTL and testbench

WATCHDOG_MULTI -- requirements
Module: watchdog_multi

---
 rtl/watchdog_multi.sv | 124 ++++++++++++
 tb/tb_watchdog_multi.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/watchdog_multi.sv
// N_CH independent heartbeat watchdogs with warning, optional early-kick window and a shared,
// retriggerable force_reset pulse plus a saturating trip counter.
module watchdog_multi #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 1000,
    parameter int WARN_AT    = 750,
    parameter int WINDOW_MIN = 0,
    parameter int PULSE_LEN  = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N_CH-1:0] enable,
    input  logic [N_CH-1:0] heartbeat,
    input  logic [N_CH-1:0] clear_fault,
    output logic [N_CH-1:0] warning,
    output logic [N_CH-1:0] triggered,
    output logic [N_CH-1:0] early_fault,
    output logic            force_reset,
    output logic [7:0]      fault_count
);

    if (!(WINDOW_MIN >= 0 && WINDOW_MIN < WARN_AT && WARN_AT < TIMEOUT &&
          (CNT_W >= 32 || TIMEOUT < (64'd1 << CNT_W)) && PULSE_LEN >= 1)) begin : g_bad_params
        $error("watchdog_multi: illegal parameter combination");
    end

    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] TRIP_AT_C = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WARN_AT_C = CNT_W'(WARN_AT - 1);
    localparam logic [CNT_W-1:0] WIN_C     = CNT_W'(WINDOW_MIN);
    localparam bit               WIN_EN    = (WINDOW_MIN != 0);
    localparam logic [PW-1:0]    PULSE_C   = PW'(PULSE_LEN);

    typedef enum logic [1:0] {IDLE, RUN, WARN, TRIPPED} state_t;

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  early_d;
    logic [N_CH-1:0]  enter_trip;
    logic             trip_pend;
    logic [PW-1:0]    pulse_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            early_fault <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            early_fault <= early_d;
        end
    end

    // Priority: clear > disable > tripped hold > heartbeat > count.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            early_d[i] = early_fault[i];
            if (clear_fault[i]) begin
                cnt_d[i]   = '0;
                early_d[i] = 1'b0;
                state_d[i] = enable[i] ? RUN : IDLE;
            end else if (!enable[i]) begin
                cnt_d[i] = '0;
                if (state_q[i] != TRIPPED) state_d[i] = IDLE;
            end else if (state_q[i] == TRIPPED) begin
                state_d[i] = TRIPPED;
            end else if (heartbeat[i]) begin
                if (WIN_EN && state_q[i] != IDLE && cnt_q[i] < WIN_C) begin
                    state_d[i] = TRIPPED;
                    early_d[i] = 1'b1;
                end else begin
                    cnt_d[i]   = '0;
                    state_d[i] = RUN;
                end
            end else if (state_q[i] == IDLE) begin
                cnt_d[i]   = '0;
                state_d[i] = RUN;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
                if (cnt_q[i] == TRIP_AT_C)      state_d[i] = TRIPPED;
                else if (cnt_q[i] >= WARN_AT_C) state_d[i] = WARN;
            end
            enter_trip[i] = (state_d[i] == TRIPPED) && (state_q[i] != TRIPPED);
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            warning[i]   = (state_q[i] == WARN);
            triggered[i] = (state_q[i] == TRIPPED);
        end
    end

    // Trips are collapsed into one event per cycle; the pulse starts one edge after the trip.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trip_pend   <= 1'b0;
            pulse_cnt   <= '0;
            force_reset <= 1'b0;
            fault_count <= '0;
        end else begin
            trip_pend <= |enter_trip;
            if (trip_pend) begin
                pulse_cnt   <= PULSE_C;
                force_reset <= 1'b1;
                if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
            end else if (pulse_cnt != '0) begin
                pulse_cnt   <= pulse_cnt - 1'b1;
                force_reset <= (pulse_cnt != PW'(1));
            end
        end
    end

endmodule

// File: tb/tb_watchdog_multi.sv
// Directed bench for watchdog_multi: reset, timeout, kicking, window fault, pulse reload, clear and reset.
module tb_watchdog_multi;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] enable, heartbeat, clear_fault;
    logic [1:0] warning, triggered, early_fault;
    logic       force_reset;
    logic [7:0] fault_count;

    int checks = 0;
    int errors = 0;

    watchdog_multi #(
        .N_CH(2), .CNT_W(8), .TIMEOUT(8), .WARN_AT(6), .WINDOW_MIN(2), .PULSE_LEN(4)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .heartbeat(heartbeat),
        .clear_fault(clear_fault), .warning(warning), .triggered(triggered),
        .early_fault(early_fault), .force_reset(force_reset), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0;
        enable = '0; heartbeat = '0; clear_fault = '0;

        // Reset holds everything at zero whatever the inputs do
        for (int i = 0; i < 4; i++) begin
            enable = 2'($urandom); heartbeat = 2'($urandom); clear_fault = 2'($urandom);
            step();
            check($sformatf("reset_outs_%0d", i),
                  32'({warning, triggered, early_fault, force_reset, fault_count}), 32'd0);
        end
        enable = '0; heartbeat = '0; clear_fault = '0;
        rstn = 1'b1;
        step();
        check("idle_after_reset", 32'({warning, triggered, early_fault, force_reset, fault_count}), 32'd0);

        // ch0 times out: RUN at edge 1, counter 6 at edge 7, 8 at edge 9, pulse edges 10..13
        enable = 2'b01;
        for (int i = 1; i <= 14; i++) begin
            step();
            check($sformatf("to_warn_%0d", i), 32'(warning[0]), 32'(i >= 7 && i < 9));
            check($sformatf("to_trig_%0d", i), 32'(triggered[0]), 32'(i >= 9));
            check($sformatf("to_force_%0d", i), 32'(force_reset), 32'(i >= 10 && i <= 13));
            check($sformatf("to_fcnt_%0d", i), 32'(fault_count), (i >= 10) ? 32'd1 : 32'd0);
        end
        check("to_early", 32'(early_fault), 32'd0);
        enable = 2'b00; clear_fault = 2'b01;
        step();
        clear_fault = 2'b00;
        check("clr_trig", 32'(triggered), 32'd0);
        check("clr_fcnt_kept", 32'(fault_count), 32'd1);

        // ch0 kicked every 5 cycles never warns or trips
        enable = 2'b01;
        for (int i = 1; i <= 100; i++) begin
            heartbeat = (i % 5 == 0) ? 2'b01 : 2'b00;
            step();
            check($sformatf("kick_quiet_%0d", i), 32'({warning, triggered, force_reset}), 32'd0);
        end
        heartbeat = '0; enable = '0;
        step();

        // ch1 kicked at counter 1 -> early fault trip
        enable = 2'b10;
        step();
        step();
        heartbeat = 2'b10;
        step();
        heartbeat = 2'b00;
        check("early_trig", 32'(triggered), 32'h2);
        check("early_flag", 32'(early_fault), 32'h2);
        step();
        check("early_force", 32'(force_reset), 32'd1);
        check("early_fcnt", 32'(fault_count), 32'd2);
        for (int i = 0; i < 4; i++) step();
        check("early_force_end", 32'(force_reset), 32'd0);

        // ch1 cleared, then kicked at counter 7 (in WARN) -> no trip, warning drops
        clear_fault = 2'b10;
        step();
        clear_fault = 2'b00;
        check("clr1_trig", 32'(triggered), 32'd0);
        check("clr1_early", 32'(early_fault), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("late_warn_%0d", i), 32'(warning[1]), 32'(i >= 6));
        end
        heartbeat = 2'b10;
        step();
        heartbeat = 2'b00;
        check("late_kick_trig", 32'(triggered), 32'd0);
        check("late_kick_warn", 32'(warning), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("late_after_%0d", i), 32'({warning, triggered}), 32'd0);
        end
        enable = 2'b00;
        step();

        // Both channels trip on the same edge -> one event
        enable = 2'b11;
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("dual_trig_%0d", i), 32'(triggered), (i == 9) ? 32'h3 : 32'h0);
        end
        step();
        check("dual_fcnt", 32'(fault_count), 32'd3);
        check("dual_force", 32'(force_reset), 32'd1);
        clear_fault = 2'b11; enable = 2'b00;
        step();
        clear_fault = 2'b00;
        for (int i = 0; i < 4; i++) step();
        check("dual_force_end", 32'(force_reset), 32'd0);

        // ch0 trips at edge 9, ch1 at edge 11 -> pulse reloads, high edges 10..15
        enable = 2'b01;
        step();
        step();
        enable = 2'b11;
        for (int i = 3; i <= 18; i++) begin
            step();
            check($sformatf("reload_force_%0d", i), 32'(force_reset), 32'(i >= 10 && i <= 15));
            check($sformatf("reload_fcnt_%0d", i), 32'(fault_count),
                  (i < 10) ? 32'd3 : ((i < 12) ? 32'd4 : 32'd5));
            if (i == 9)  check("reload_trig_ch0", 32'(triggered), 32'h1);
            if (i == 11) check("reload_trig_both", 32'(triggered), 32'h3);
        end

        // Clear with a simultaneous kick on ch0: clear wins, counter restarts from 0
        clear_fault = 2'b01; heartbeat = 2'b01;
        step();
        clear_fault = 2'b00; heartbeat = 2'b00;
        check("clrkick_trig", 32'(triggered), 32'h2);
        check("clrkick_early", 32'(early_fault[0]), 32'd0);
        check("clrkick_warn", 32'(warning), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("clrkick_warn_%0d", i), 32'(warning[0]), 32'(i >= 6 && i < 8));
        end
        check("retrip_trig", 32'(triggered), 32'h3);
        step();
        check("retrip_force", 32'(force_reset), 32'd1);
        check("retrip_fcnt", 32'(fault_count), 32'd6);
        step();
        check("retrip_force_mid", 32'(force_reset), 32'd1);

        // Asynchronous reset mid-pulse clears outputs without waiting for an edge
        rstn = 1'b0;
        #1;
        check("arst_force", 32'(force_reset), 32'd0);
        check("arst_fcnt", 32'(fault_count), 32'd0);
        check("arst_flags", 32'({warning, triggered, early_fault}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
